// File: rtl/uart_rx_fifo.sv
// UART receiver, mid-bit sampling, into a first-word-fall-through FIFO; a word is visible the cycle after its stop sample.
// No backpressure: a push into a full FIFO is dropped and sets sticky overrun. Define UART_RX_SYNC_EN for a 2-flop d_in synchroniser (+2 cycles).
module uart_rx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              ARstN,
  input  logic              en,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              d_in,
  input  logic              rd,
  output logic [DATA_W-1:0] d_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_W + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge ARstN) begin
    if (!ARstN) sync <= 2'b11;
    else        sync <= {sync[0], d_in};
  end
  assign rx = sync[1];
`else
  assign rx = d_in;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     nbits;
  logic [DATA_W-1:0] shreg;
  logic              p_en;
  logic              p_odd;
  logic              perr;
  logic              tick;
  logic              half;
  logic              push;
  logic [WW-1:0]     push_word;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign half = (cnt == CW'(H - 1));

  // The stop sample itself is the push: the word lands in the FIFO on that edge.
  assign push      = (state == STOP) && tick;
  assign push_word = {~rx, perr, shreg};

  always_ff @(posedge clk or negedge ARstN) begin
    if (!ARstN) begin
      state <= IDLE;
      cnt   <= '0;
      nbits <= '0;
      shreg <= '0;
      p_en  <= 1'b0;
      p_odd <= 1'b0;
      perr  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx && en) begin
            state <= START;
            cnt   <= '0;
            nbits <= '0;
            p_en  <= parity_en;
            p_odd <= parity_odd;
            perr  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (half) begin
            cnt <= '0;
            if (rx) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {rx, shreg[DATA_W-1:1]};
            nbits <= nbits + BW'(1);
            if (nbits == BW'(DATA_W - 1)) state <= p_en ? PARITY : STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            cnt   <= '0;
            perr  <= ^shreg ^ rx ^ p_odd;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            cnt <= '0;
            if (rx) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr;
  logic [WW-1:0] head;

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = rd && (count != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= push_word;
  end

  always_ff @(posedge clk or negedge ARstN) begin
    if (!ARstN) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (pop)              overrun <= 1'b0;
      else if (push && full) overrun <= 1'b1;
    end
  end

  assign valid      = (count != '0);
  assign head       = mem[rptr];
  assign d_out      = valid ? head[DATA_W-1:0] : '0;
  assign parity_err = valid & head[DATA_W];
  assign frame_err  = valid & head[DATA_W+1];

endmodule
